// File: rtl/tt_sweep.sv
// tt_sweep: truth-table sweeper. Drives every minterm index onto vec in ascending order,
// holds it SETTLE cycles, samples the downstream response f_in, and builds table_out.
// When TT_COMPARE_EN is defined, the captured table is also compared against expected
// at the end of the sweep.
//
// Parameters:
//   N_IN   - minterm width; the truth table is 2**N_IN bits
//   SETTLE - cycles each minterm is held before sampling (1..15)
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - request a sweep (sampled only in IDLE)
//   f_in      - downstream function response for the current vec
//   expected  - reference truth table (bit m = expected response at minterm m)
//   vec       - minterm index driven downstream (MSB = first input A)
//   busy      - sweep in progress (DRIVE or SAMPLE)
//   done      - one-cycle end-of-sweep pulse
//   table_out - captured truth table
//   mismatch  - table_out ^ expected, registered at end of sweep (0 without TT_COMPARE_EN)
//   pass      - mismatch is all zero (0 without TT_COMPARE_EN)
// Configuration macro: TT_COMPARE_EN
module tt_sweep #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 f_in,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [2**N_IN-1:0]   mismatch,
  output logic                 pass
);

  localparam int unsigned W = 2**N_IN;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  logic [1:0]      r_state;
  logic [N_IN-1:0] r_vec;
  logic [3:0]      r_cnt;
  logic [W-1:0]    r_table;
  logic [W-1:0]    w_table_nxt;
  logic            w_last;
  logic            w_go;
  logic            w_finish;

  // Table with the current minterm's response merged in; used both for capture and for the
  // final compare so the last sample is included in mismatch/pass.
  always_comb begin
    w_table_nxt        = r_table;
    w_table_nxt[r_vec] = f_in;
  end

  assign w_last   = &r_vec;
  assign w_go     = (r_state == S_IDLE) && start;
  assign w_finish = (r_state == S_SAMPLE) && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_table <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_DRIVE;
            r_vec   <= '0;
            r_table <= '0;
            r_cnt   <= SETTLE_V;
          end
        end
        S_DRIVE: begin
          // Counter is loaded with SETTLE on entry, so leaving at 1 gives SETTLE cycles.
          if (r_cnt <= 4'd1) begin
            r_state <= S_SAMPLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          r_table <= w_table_nxt;
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_vec   <= r_vec + 1'b1;
            r_cnt   <= SETTLE_V;
            r_state <= S_DRIVE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef TT_COMPARE_EN
  logic [W-1:0] r_mismatch;
  logic         r_pass;

  // expected is looked at only on the SAMPLE->DONE edge, so mid-sweep changes are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= '0;
      r_pass     <= 1'b0;
    end else if (w_go) begin
      r_mismatch <= '0;
      r_pass     <= 1'b0;
    end else if (w_finish) begin
      r_mismatch <= w_table_nxt ^ expected;
      r_pass     <= ~|(w_table_nxt ^ expected);
    end
  end

  assign mismatch = r_mismatch;
  assign pass     = r_pass;
`else
  logic w_unused_cmp;
  assign w_unused_cmp = ^{expected, w_go, w_finish};
  assign mismatch     = '0;
  assign pass         = 1'b0;
`endif

  assign vec       = r_vec;
  assign busy      = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
  assign done      = (r_state == S_DONE);
  assign table_out = r_table;

endmodule

// File: tb/tb_tt_sweep.sv
// Scoreboard bench for tt_sweep with default parameters. The downstream function is the
// product of maxterms 10..13 (output 0 only at minterms 10-13), whose truth table is 16'hC3FF.
// Edge numbering: the edge that samples start is edge 0; done is reported against the edge
// that samples it high, which must be edge 33.
module tb_tt_sweep;
  localparam int N_IN   = 4;
  localparam int SETTLE = 1;
  localparam int W      = 16;
  localparam logic [W-1:0] TT_REF = 16'hC3FF;

`ifdef TT_COMPARE_EN
  localparam logic CMP = 1'b1;
`else
  localparam logic CMP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            f_in;
  logic [W-1:0]    expected;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic [W-1:0]    table_out;
  logic [W-1:0]    mismatch;
  logic            pass;

  typedef struct {
    logic [W-1:0] tbl;
    logic [W-1:0] mm;
    logic         ps;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   dones  = 0;

  tt_sweep #(
    .N_IN  (N_IN),
    .SETTLE(SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .f_in     (f_in),
    .expected (expected),
    .vec      (vec),
    .busy     (busy),
    .done     (done),
    .table_out(table_out),
    .mismatch (mismatch),
    .pass     (pass)
  );

  always #5 clk = ~clk;

  // Downstream function: zero only at maxterms 10..13.
  assign f_in = !((vec >= 4'd10) && (vec <= 4'd13));

  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: every done pulse pops one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      dones++;
      check("sb_nonempty_on_done", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("done_edge", edge_n + 1, mon_e.due);
        check("table_out", 32'(table_out), 32'(mon_e.tbl));
        check("mismatch", 32'(mismatch), 32'(mon_e.mm));
        check("pass", 32'(pass), 32'(mon_e.ps));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] mm, input logic ps, input int due);
    exp_t e;
    e.tbl = TT_REF;
    e.mm  = mm;
    e.ps  = ps;
    e.due = due;
    sb.push_back(e);
  endtask

  // Returns at the negedge just after edge 0, with start dropped.
  task automatic start_sweep(input logic [W-1:0] exp_v, input logic [W-1:0] mm, input logic ps,
                             output int s_edge);
    @(negedge clk);
    expected = exp_v;
    start    = 1'b1;
    s_edge   = edge_n + 1;
    push_exp(mm, ps, s_edge + 33);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (dones < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("done_within_bound", 32'(dones >= target), 32'd1);
  endtask

  initial begin
    int s;
    int base;
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    expected = '0;

    // Reset state
    #3;
    check("rst_vec", 32'(vec), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_table", 32'(table_out), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Sweep with matching reference; vec walks 0..15, two cycles per value
    start_sweep(16'hC3FF, 16'h0000, CMP, s);
    for (int k = 0; k < 32; k++) begin
      check("vec_step", 32'(vec), 32'(k / 2));
      check("busy_sweep", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("busy_done_cycle", 32'(busy), 32'd0);
    wait_done(1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    check("idle_hold_vec", 32'(vec), 32'd15);
    check("idle_hold_table", 32'(table_out), 32'(TT_REF));
    check("idle_hold_pass", 32'(pass), 32'(CMP));

    // Reference off by one bit; expected wiggles mid-sweep but is restored before the end
    start_sweep(16'hC3FE, CMP ? 16'h0001 : 16'h0000, 1'b0, s);
    repeat (6) @(negedge clk);
    expected = 16'h0000;
    repeat (10) @(negedge clk);
    expected = 16'hC3FE;
    wait_done(2);
    repeat (3) @(negedge clk);

    // start held high across edges 0..40: one done by edge 40, re-sweep sampled at edge 34
    base = dones;
    @(negedge clk);
    expected = 16'hC3FF;
    start    = 1'b1;
    s        = edge_n + 1;
    push_exp(16'h0000, CMP, s + 33);
    push_exp(16'h0000, CMP, s + 34 + 33);
    n = 0;
    while (edge_n < s + 40 && n < 80) begin
      @(negedge clk);
      n++;
      if (edge_n == s + 33) check("gap_idle_busy", 32'(busy), 32'd0);
      if (edge_n == s + 34) begin
        check("resweep_busy", 32'(busy), 32'd1);
        check("resweep_vec", 32'(vec), 32'd0);
      end
    end
    start = 1'b0;
    check("one_done_by_edge40", dones, base + 1);
    wait_done(base + 2);
    repeat (3) @(negedge clk);

    // Reset mid-sweep at vec==7
    base = dones;
    start_sweep(16'hC3FF, 16'h0000, CMP, s);
    n = 0;
    while (vec != 4'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reached_vec7", 32'(vec), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_vec", 32'(vec), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_table", 32'(table_out), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pass", 32'(pass), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", dones, base);
    start_sweep(16'hC3FF, 16'h0000, CMP, s);
    wait_done(base + 1);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
